sram_oq_scheduler: RTL and testbench

Per-queue pointer manager and single-port SRAM command scheduler for the SRAM output-queue datapath. It accepts word-write requests tagged with a one-hot output queue and tracks head/tail/occupancy for each of NUM_QUEUES circular regions. Each region is QUEUE_SIZE words. Each cycle it issues at most one SRAM command, either a write or a round-robin read for a downstream port that is ready. It sits between the input FIFO drain logic and the SRAM controller.

---
 rtl/sram_oq_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sram_oq_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_oq_scheduler.sv
// Per-queue head/tail/count tracking for NUM_QUEUES circular SRAM regions.
// Issues one SRAM command per cycle: a write, or a round-robin read.
module sram_oq_scheduler #(
    parameter int NUM_QUEUES     = 5,
    parameter int QUEUE_ID_WIDTH = 3,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int QUEUE_SIZE     = 104857
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 wr_req,
    input  logic [NUM_QUEUES-1:0]                wr_queue,
    output logic                                 wr_ready,
    output logic                                 wr_err,
    input  logic [NUM_QUEUES-1:0]                out_ready,
    output logic                                 mem_cmd_valid,
    output logic                                 mem_cmd_we,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_cmd_addr,
    output logic [QUEUE_ID_WIDTH-1:0]            mem_cmd_queue,
    output logic [NUM_QUEUES-1:0]                q_empty,
    output logic [NUM_QUEUES-1:0]                q_full,
    output logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_free_words
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int QW = QUEUE_ID_WIDTH;
    localparam logic [AW-1:0] QSIZE = AW'(QUEUE_SIZE);
    localparam logic [AW-1:0] QLAST = AW'(QUEUE_SIZE - 1);

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

    logic [AW-1:0] head_q  [NUM_QUEUES];
    logic [AW-1:0] head_d  [NUM_QUEUES];
    logic [AW-1:0] tail_q  [NUM_QUEUES];
    logic [AW-1:0] tail_d  [NUM_QUEUES];
    logic [AW-1:0] count_q [NUM_QUEUES];
    logic [AW-1:0] count_d [NUM_QUEUES];

    logic [QW-1:0] rr_q, rr_d;
    prio_e         prio_q, prio_d;

    logic                           cmd_valid_q, cmd_valid_d;
    logic                           cmd_we_q, cmd_we_d;
    logic [AW-1:0]                  cmd_addr_q, cmd_addr_d;
    logic [QW-1:0]                  cmd_queue_q, cmd_queue_d;
    logic                           wr_err_q, wr_err_d;
    logic [NUM_QUEUES-1:0]          empty_q, empty_d;
    logic [NUM_QUEUES-1:0]          full_q, full_d;
    logic [NUM_QUEUES*AW-1:0]       free_q, free_d;

    logic                  wr_onehot, wr_full, wr_cand;
    logic                  rd_any, wr_grant, rd_grant;
    logic [QW-1:0]         rd_idx;
    logic [NUM_QUEUES-1:0] elig;
    int                    idx;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == QLAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_onehot = $onehot(wr_queue);
        wr_full   = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            wr_full |= wr_queue[q] && (count_q[q] == QSIZE);
            elig[q]  = (count_q[q] != '0) && out_ready[q];
        end
        wr_cand = wr_req && wr_onehot && !wr_full;

        // First eligible queue at or above rr_q, wrapping around.
        rd_any = 1'b0;
        rd_idx = '0;
        idx    = 0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            idx = (int'(rr_q) + i) % NUM_QUEUES;
            if (!rd_any && elig[QW'(idx)]) begin
                rd_any = 1'b1;
                rd_idx = QW'(idx);
            end
        end

        wr_grant = wr_cand && (!rd_any || prio_q == PRIO_WR);
        rd_grant = rd_any && !wr_grant;
        wr_ready = resetn && (wr_grant || (wr_req && !wr_onehot));
        wr_err_d = wr_req && !wr_onehot;

        prio_d = prio_q;
        if (wr_cand && rd_any)
            prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;

        rr_d = rr_q;
        if (rd_grant)
            rr_d = (rd_idx == QW'(NUM_QUEUES - 1)) ? '0 : rd_idx + 1'b1;

        cmd_valid_d = 1'b0;
        cmd_we_d    = 1'b0;
        cmd_addr_d  = '0;
        cmd_queue_d = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            head_d[q]  = head_q[q];
            tail_d[q]  = tail_q[q];
            count_d[q] = count_q[q];
            if (wr_grant && wr_queue[q]) begin
                cmd_valid_d = 1'b1;
                cmd_we_d    = 1'b1;
                cmd_addr_d  = AW'(q * QUEUE_SIZE) + tail_q[q];
                cmd_queue_d = QW'(q);
                tail_d[q]   = wrap_inc(tail_q[q]);
                count_d[q]  = count_q[q] + 1'b1;
            end
            if (rd_grant && rd_idx == QW'(q)) begin
                cmd_valid_d = 1'b1;
                cmd_addr_d  = AW'(q * QUEUE_SIZE) + head_q[q];
                cmd_queue_d = QW'(q);
                head_d[q]   = wrap_inc(head_q[q]);
                count_d[q]  = count_q[q] - 1'b1;
            end
            empty_d[q]          = (count_d[q] == '0);
            full_d[q]           = (count_d[q] == QSIZE);
            free_d[q*AW +: AW]  = QSIZE - count_d[q];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head_q[q]  <= '0;
                tail_q[q]  <= '0;
                count_q[q] <= '0;
            end
            rr_q        <= '0;
            prio_q      <= PRIO_WR;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_queue_q <= '0;
            wr_err_q    <= 1'b0;
            empty_q     <= '1;
            full_q      <= '0;
            free_q      <= {NUM_QUEUES{QSIZE}};
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head_q[q]  <= head_d[q];
                tail_q[q]  <= tail_d[q];
                count_q[q] <= count_d[q];
            end
            rr_q        <= rr_d;
            prio_q      <= prio_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_queue_q <= cmd_queue_d;
            wr_err_q    <= wr_err_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            free_q      <= free_d;
        end
    end

    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_we    = cmd_we_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign mem_cmd_queue = cmd_queue_q;
    assign wr_err        = wr_err_q;
    assign q_empty       = empty_q;
    assign q_full        = full_q;
    assign q_free_words  = free_q;

endmodule

// File: tb/tb_sram_oq_scheduler.sv
// Scoreboard bench for sram_oq_scheduler; a small-region second instance
// exercises the full/wrap path in few cycles.
module tb_sram_oq_scheduler;
    localparam int NQ  = 5;
    localparam int QW  = 3;
    localparam int AW  = 19;
    localparam int QS  = 104857;
    localparam int SQS = 6;

    typedef struct packed {
        logic          we;
        logic [QW-1:0] q;
        logic [AW-1:0] addr;
    } cmd_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             wr_req;
    logic [NQ-1:0]    wr_queue;
    logic [NQ-1:0]    out_ready;

    logic             wr_ready, wr_err, mem_cmd_valid, mem_cmd_we;
    logic [AW-1:0]    mem_cmd_addr;
    logic [QW-1:0]    mem_cmd_queue;
    logic [NQ-1:0]    q_empty, q_full;
    logic [NQ*AW-1:0] q_free_words;

    logic             s_wr_ready, s_wr_err, s_mem_cmd_valid, s_mem_cmd_we;
    logic [AW-1:0]    s_mem_cmd_addr;
    logic [QW-1:0]    s_mem_cmd_queue;
    logic [NQ-1:0]    s_q_empty, s_q_full;
    logic [NQ*AW-1:0] s_q_free_words;

    cmd_t exp_q[$];
    cmd_t obs_q[$];
    int   total  = 0;
    int   passed = 0;

    sram_oq_scheduler dut (
        .clk(clk), .resetn(resetn), .wr_req(wr_req), .wr_queue(wr_queue),
        .wr_ready(wr_ready), .wr_err(wr_err), .out_ready(out_ready),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_queue(mem_cmd_queue),
        .q_empty(q_empty), .q_full(q_full), .q_free_words(q_free_words)
    );

    sram_oq_scheduler #(.QUEUE_SIZE(SQS)) dut_s (
        .clk(clk), .resetn(resetn), .wr_req(wr_req), .wr_queue(wr_queue),
        .wr_ready(s_wr_ready), .wr_err(s_wr_err), .out_ready(out_ready),
        .mem_cmd_valid(s_mem_cmd_valid), .mem_cmd_we(s_mem_cmd_we),
        .mem_cmd_addr(s_mem_cmd_addr), .mem_cmd_queue(s_mem_cmd_queue),
        .q_empty(s_q_empty), .q_full(s_q_full), .q_free_words(s_q_free_words)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (resetn && mem_cmd_valid)
            obs_q.push_back(cmd_t'{mem_cmd_we, mem_cmd_queue, mem_cmd_addr});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn    = 1'b0;
        wr_req    = 1'b0;
        wr_queue  = '0;
        out_ready = '0;
        step();
        step();
        exp_q.delete();
        obs_q.delete();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [NQ*AW-1:0] fw;
        fw        = {NQ{AW'(QS)}};
        resetn    = 1'b0;
        out_ready = '0;
        wr_req    = 1'b1;
        wr_queue  = 5'b00001;
        step();
        total++;
        if (wr_ready !== 1'b0) $display("FAIL rst_wr_ready: got %b want 0", wr_ready);
        else passed++;
        total++;
        if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_queue, wr_err} !== '0)
            $display("FAIL rst_cmd: got %b/%b/%0d/%0d/%b want zeros", mem_cmd_valid,
                     mem_cmd_we, mem_cmd_addr, mem_cmd_queue, wr_err);
        else passed++;
        total++;
        if (q_empty !== 5'h1f || q_full !== 5'h0)
            $display("FAIL rst_flags: got empty=%b full=%b want 11111/00000", q_empty, q_full);
        else passed++;
        total++;
        if (q_free_words !== fw) $display("FAIL rst_free: got %h want %h", q_free_words, fw);
        else passed++;
        wr_req = 1'b0;
    endtask

    task automatic test_write_q2();
        cmd_t e, o;
        apply_reset();
        wr_req   = 1'b1;
        wr_queue = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (wr_ready !== 1'b1) $display("FAIL wq2_ready: got %b want 1", wr_ready);
            else passed++;
            exp_q.push_back(cmd_t'{1'b1, 3'd2, AW'(2 * QS + i)});
            step();
        end
        wr_req = 1'b0;
        step();
        total++;
        if (q_free_words[2*AW +: AW] !== AW'(QS - 3))
            $display("FAIL wq2_free: got %0d want %0d", q_free_words[2*AW +: AW], QS - 3);
        else passed++;
        total++;
        if (q_empty !== 5'b11011) $display("FAIL wq2_empty: got %b want 11011", q_empty);
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL wq2_cmd: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL wq2_cmd: got %h want %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) $display("FAIL wq2_extra: got %0d want 0", obs_q.size());
        else passed++;
    endtask

    task automatic test_full_wrap();
        apply_reset();
        wr_req   = 1'b1;
        wr_queue = 5'b00001;
        for (int i = 0; i < SQS; i++) begin
            #1;
            total++;
            if (s_wr_ready !== 1'b1) $display("FAIL fill_ready: got %b want 1", s_wr_ready);
            else passed++;
            step();
            total++;
            if ({s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr} !== {2'b11, AW'(i)})
                $display("FAIL fill_cmd: got %b/%b/%0d want 1/1/%0d",
                         s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr, i);
            else passed++;
        end
        #1;
        total++;
        if (s_wr_ready !== 1'b0 || s_q_full[0] !== 1'b1)
            $display("FAIL full_bp: got ready=%b full=%b want 0/1", s_wr_ready, s_q_full[0]);
        else passed++;
        step();
        total++;
        if (s_mem_cmd_valid !== 1'b0 || s_q_free_words[AW-1:0] !== '0)
            $display("FAIL full_hold: got valid=%b free=%0d want 0/0",
                     s_mem_cmd_valid, s_q_free_words[AW-1:0]);
        else passed++;
        out_ready = 5'b00001;
        step();
        out_ready = '0;
        total++;
        if ({s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr} !== {2'b10, AW'(0)})
            $display("FAIL full_rd: got %b/%b/%0d want 1/0/0",
                     s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr);
        else passed++;
        #1;
        total++;
        if (s_wr_ready !== 1'b1) $display("FAIL wrap_ready: got %b want 1", s_wr_ready);
        else passed++;
        step();
        wr_req = 1'b0;
        total++;
        if ({s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr} !== {2'b11, AW'(0)})
            $display("FAIL wrap_wr: got %b/%b/%0d want 1/1/0",
                     s_mem_cmd_valid, s_mem_cmd_we, s_mem_cmd_addr);
        else passed++;
    endtask

    task automatic test_round_robin();
        cmd_t e, o;
        int qs[3];
        qs = '{0, 1, 4};
        apply_reset();
        wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_queue = NQ'(1) << qs[k];
            for (int j = 0; j < 2; j++) begin
                exp_q.push_back(cmd_t'{1'b1, QW'(qs[k]), AW'(qs[k] * QS + j)});
                step();
            end
        end
        wr_req    = 1'b0;
        out_ready = 5'h1f;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 3; k++)
                exp_q.push_back(cmd_t'{1'b0, QW'(qs[k]), AW'(qs[k] * QS + j)});
        repeat (6) step();
        out_ready = '0;
        step();
        total++;
        if (q_empty !== 5'h1f) $display("FAIL rr_empty: got %b want 11111", q_empty);
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL rr_cmd: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL rr_cmd: got %h want %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) $display("FAIL rr_extra: got %0d want 0", obs_q.size());
        else passed++;
    endtask

    task automatic test_conflict();
        cmd_t e, o;
        logic [4:0] rdy_pat;
        rdy_pat = 5'b10101;
        apply_reset();
        wr_req   = 1'b1;
        wr_queue = 5'b00010;
        for (int j = 0; j < 2; j++) begin
            exp_q.push_back(cmd_t'{1'b1, 3'd1, AW'(QS + j)});
            step();
        end
        wr_queue  = 5'b01000;
        out_ready = 5'b00010;
        exp_q.push_back(cmd_t'{1'b1, 3'd3, AW'(3 * QS)});
        exp_q.push_back(cmd_t'{1'b0, 3'd1, AW'(QS)});
        exp_q.push_back(cmd_t'{1'b1, 3'd3, AW'(3 * QS + 1)});
        exp_q.push_back(cmd_t'{1'b0, 3'd1, AW'(QS + 1)});
        exp_q.push_back(cmd_t'{1'b1, 3'd3, AW'(3 * QS + 2)});
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (wr_ready !== rdy_pat[c])
                $display("FAIL cf_ready[%0d]: got %b want %b", c, wr_ready, rdy_pat[c]);
            else passed++;
            step();
        end
        wr_req    = 1'b0;
        out_ready = '0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL cf_cmd: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL cf_cmd: got %h want %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) $display("FAIL cf_extra: got %0d want 0", obs_q.size());
        else passed++;
    endtask

    task automatic test_invalid();
        cmd_t e, o;
        logic [NQ*AW-1:0] fw;
        fw          = {NQ{AW'(QS)}};
        fw[AW-1:0]  = AW'(QS - 1);
        apply_reset();
        wr_req   = 1'b1;
        wr_queue = 5'b00001;
        exp_q.push_back(cmd_t'{1'b1, 3'd0, AW'(0)});
        step();
        wr_queue = 5'b00101;
        #1;
        total++;
        if (wr_ready !== 1'b1) $display("FAIL inv_ready: got %b want 1", wr_ready);
        else passed++;
        step();
        total++;
        if (wr_err !== 1'b1 || mem_cmd_valid !== 1'b0)
            $display("FAIL inv_err: got err=%b valid=%b want 1/0", wr_err, mem_cmd_valid);
        else passed++;
        total++;
        if (q_free_words !== fw) $display("FAIL inv_free: got %h want %h", q_free_words, fw);
        else passed++;
        wr_queue = '0;
        #1;
        total++;
        if (wr_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", wr_ready);
        else passed++;
        step();
        wr_req = 1'b0;
        total++;
        if (wr_err !== 1'b1 || mem_cmd_valid !== 1'b0)
            $display("FAIL zero_err: got err=%b valid=%b want 1/0", wr_err, mem_cmd_valid);
        else passed++;
        step();
        total++;
        if (wr_err !== 1'b0 || q_free_words !== fw)
            $display("FAIL inv_after: got err=%b free=%h want 0/%h", wr_err, q_free_words, fw);
        else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL inv_cmd: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL inv_cmd: got %h want %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) $display("FAIL inv_extra: got %0d want 0", obs_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        cmd_t e, o;
        logic [NQ*AW-1:0] fw;
        fw = {NQ{AW'(QS)}};
        apply_reset();
        wr_req   = 1'b1;
        wr_queue = 5'b00100;
        step();
        step();
        total++;
        if (mem_cmd_valid !== 1'b1) $display("FAIL mid_pre: got %b want 1", mem_cmd_valid);
        else passed++;
        resetn = 1'b0;
        #1;
        total++;
        if ({mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_queue, wr_ready} !== '0)
            $display("FAIL mid_cmd: got %b/%b/%0d/%0d ready=%b want zeros", mem_cmd_valid,
                     mem_cmd_we, mem_cmd_addr, mem_cmd_queue, wr_ready);
        else passed++;
        total++;
        if (q_empty !== 5'h1f || q_free_words !== fw)
            $display("FAIL mid_flags: got empty=%b free=%h want 11111/%h", q_empty, q_free_words, fw);
        else passed++;
        wr_req = 1'b0;
        step();
        exp_q.delete();
        obs_q.delete();
        resetn   = 1'b1;
        wr_req   = 1'b1;
        wr_queue = 5'b00010;
        exp_q.push_back(cmd_t'{1'b1, 3'd1, AW'(QS)});
        step();
        wr_req = 1'b0;
        step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) $display("FAIL mid_cmd_post: got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL mid_cmd_post: got %h want %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_q.size() != 0) $display("FAIL mid_extra: got %0d want 0", obs_q.size());
        else passed++;
    endtask

    initial begin
        resetn    = 1'b0;
        wr_req    = 1'b0;
        wr_queue  = '0;
        out_ready = '0;
        test_reset();
        test_write_q2();
        test_full_wrap();
        test_round_robin();
        test_conflict();
        test_invalid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
